sfifo_rd_stream: RTL

//  Read-side stage that sits directly after a show-ahead sfifo_ctrl + RAM pair.

---
 rtl/sfifo_rd_stream.sv | 103 ++++++++++
 1 files changed

// File: rtl/sfifo_rd_stream.sv
// Read-side stage behind a show-ahead FIFO + RAM pair: issues reads against credits and
// re-times the RAM data into a small output buffer presented as a valid/ready stream.
module sfifo_rd_stream #(
    parameter  int WIDTH_DATA = 36,
    parameter  int RD_LATENCY = 1,
    localparam int BUF_DEPTH  = RD_LATENCY + 2,
    localparam int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [WIDTH_DATA-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_DATA-1:0] m_data,
    output logic [CNT_W-1:0]      occ,
    output logic [CNT_W-1:0]      inflight
);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [RD_LATENCY-1:0] lat_q, lat_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      infl_q, infl_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH_DATA-1:0] buf_mem [BUF_DEPTH];

    logic           clear;
    logic           capture;
    logic           pop;
    logic [CNT_W:0] credit_used;

    assign clear       = sys_rst | flush;
    assign credit_used = {1'b0, occ_q} + {1'b0, infl_q};
    // Credits come from registered counters only, so m_ready never reaches fifo_ren.
    assign fifo_ren    = ~clear & ~fifo_empty & (credit_used < (CNT_W + 1)'(BUF_DEPTH));
    assign capture     = lat_q[RD_LATENCY-1];
    assign m_valid     = (occ_q != '0);
    assign pop         = m_valid & m_ready;
    assign m_data      = m_valid ? buf_mem[rd_ptr_q] : '0;
    assign occ         = occ_q;
    assign inflight    = infl_q;

    assign lat_d[0] = fifo_ren;
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_lat
        assign lat_d[gi] = lat_q[gi-1];
    end

    always_comb begin
        occ_d    = occ_q;
        infl_d   = infl_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({capture, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        case ({fifo_ren, capture})
            2'b10:   infl_d = infl_q + CNT_W'(1);
            2'b01:   infl_d = infl_q - CNT_W'(1);
            default: infl_d = infl_q;
        endcase
        // Depth is generally not a power of two, so wrap explicitly.
        if (capture) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (clear) begin
            lat_q    <= '0;
            occ_q    <= '0;
            infl_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            lat_q    <= lat_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // A write during clear is harmless: occupancy is zeroed so the entry is never read.
    always_ff @(posedge sys_clk) begin
        if (capture) begin
            buf_mem[wr_ptr_q] <= fifo_rdata;
        end
    end

    credit_bound: assert property (@(posedge sys_clk) disable iff (sys_rst)
        credit_used <= (CNT_W + 1)'(BUF_DEPTH));
    no_overflow: assert property (@(posedge sys_clk) disable iff (clear)
        capture |-> (occ_q != CNT_W'(BUF_DEPTH)));

endmodule
